// File: rtl/sm_dma_pkg.sv
// sm_dma_pkg: shared register map, control bits and FSM states for the DMA engine
package sm_dma_pkg;
  localparam int DEF_LEN_W = 16;
  localparam logic [1:0] REG_SRC = 2'd0, REG_DST = 2'd1, REG_LEN = 2'd2, REG_CTRL = 2'd3;
  localparam int CTRL_START = 0, CTRL_DONE_CLR = 1;
  localparam logic [11:0] SM_DMA_BASE = 12'hbec;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;
endpackage

// File: rtl/sm_dma_if.sv
// sm_dma_if: slave register port, master bus port and done flag of the DMA engine
interface sm_dma_if;
  logic [31:0] sAddr, sWData, sRData, mAddr, mWData, mRData;
  logic sWe, mReq, mGnt, mWe, done;
  modport slave (input sAddr, sWe, sWData, mGnt, mRData, output sRData, mReq, mAddr, mWe, mWData, done);
  modport master (output sAddr, sWe, sWData, mGnt, mRData, input sRData, mReq, mAddr, mWe, mWData, done);
endinterface

// File: rtl/sm_dma_regs.sv
// sm_dma_regs: SRC/DST/LEN programming registers, CTRL strobes and readback mux
module sm_dma_regs import sm_dma_pkg::*; #(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       addr_i,
  input  logic             we_i,
  input  logic [31:0]      wdata_i,
  input  logic             busy_i,
  input  logic             done_i,
  input  logic [LEN_W-1:0] rem_i,
  output logic [31:0]      rdata_o,
  output logic [31:0]      src_o,
  output logic [31:0]      dst_o,
  output logic [LEN_W-1:0] len_o,
  output logic             start_o,
  output logic             done_clr_o
);
  logic [31:0] src_q, dst_q;
  logic [LEN_W-1:0] len_q;
  logic wr_ok;
  assign wr_ok = we_i && !busy_i;
  // Copy parameters only change while idle; addresses are kept word aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else begin
      if (wr_ok && addr_i == REG_SRC) src_q <= {wdata_i[31:2], 2'b00};
      if (wr_ok && addr_i == REG_DST) dst_q <= {wdata_i[31:2], 2'b00};
      if (wr_ok && addr_i == REG_LEN) len_q <= wdata_i[LEN_W-1:0];
    end
  end
  assign start_o = we_i && addr_i == REG_CTRL && wdata_i[CTRL_START];
  assign done_clr_o = we_i && addr_i == REG_CTRL && wdata_i[CTRL_DONE_CLR];
  assign src_o = src_q;
  assign dst_o = dst_q;
  assign len_o = len_q;
  // Readback is always allowed, busy or not
  always_comb
    rdata_o = addr_i == REG_SRC ? src_q :
              addr_i == REG_DST ? dst_q :
              addr_i == REG_LEN ? 32'(len_q) :
              (32'(rem_i) << 16) | {30'b0, done_i, busy_i};
endmodule

// File: rtl/sm_dma.sv
// sm_dma: word-copy DMA engine, read-then-write transfers under a req/gnt handshake
module sm_dma import sm_dma_pkg::*; #(
  parameter int LEN_W = DEF_LEN_W
) (
  input logic     clk,
  input logic     rst,
  sm_dma_if.slave bus
);
  state_t state_q, state_d;
  logic [31:0] src_cur_q, src_cur_d, dst_cur_q, dst_cur_d, data_q, data_d, src_cfg, dst_cfg;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_cfg;
  logic done_q, done_d, start, done_clr, busy, unused;
  assign unused = ^{bus.sAddr[31:4], bus.sAddr[1:0]};
  assign busy = state_q != S_IDLE;
  sm_dma_regs #(.LEN_W(LEN_W)) u_regs (
    .clk(clk), .rst(rst), .addr_i(bus.sAddr[3:2]), .we_i(bus.sWe), .wdata_i(bus.sWData),
    .busy_i(busy), .done_i(done_q), .rem_i(busy ? cnt_q : '0), .rdata_o(bus.sRData),
    .src_o(src_cfg), .dst_o(dst_cfg), .len_o(len_cfg), .start_o(start), .done_clr_o(done_clr)
  );
  // State register; reset aborts any copy at the next edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_cur_q <= '0;
      dst_cur_q <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_cur_q <= src_cur_d;
      dst_cur_q <= dst_cur_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end
  // Next state: START only acts when idle and wins over DONE_CLR; completion always sets done
  always_comb begin
    state_d   = state_q;
    src_cur_d = src_cur_q;
    dst_cur_d = dst_cur_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    done_d    = done_clr ? 1'b0 : done_q;
    if (state_q == S_IDLE && start) begin
      done_d = len_cfg == '0;
      if (len_cfg != '0) begin
        state_d   = S_READ;
        src_cur_d = src_cfg;
        dst_cur_d = dst_cfg;
        cnt_d     = len_cfg;
      end
    end else if (state_q == S_READ && bus.mGnt) begin
      data_d  = bus.mRData;
      state_d = S_WRITE;
    end else if (state_q == S_WRITE && bus.mGnt) begin
      src_cur_d = src_cur_q + 32'd4;
      dst_cur_d = dst_cur_q + 32'd4;
      cnt_d     = cnt_q - 1'b1;
      state_d   = cnt_q == LEN_W'(1) ? S_IDLE : S_READ;
      done_d    = done_d | (cnt_q == LEN_W'(1));
    end
  end
  assign bus.mReq   = busy;
  assign bus.mWe    = state_q == S_WRITE;
  assign bus.mAddr  = state_q == S_WRITE ? dst_cur_q : state_q == S_READ ? src_cur_q : '0;
  assign bus.mWData = state_q == S_WRITE ? data_q : '0;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_sm_dma.sv
// tb_sm_dma: directed checks of programming, copy sequencing, wrap, ignore-while-busy and reset abort
module tb_sm_dma;
  logic clk, rst;
  int tests, fails;
  sm_dma_if bus ();
  sm_dma dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction
  assign bus.mRData = mem(bus.mAddr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    bus.sAddr = {28'b0, r, 2'b00};
    bus.sWData = d;
    bus.sWe = 1'b1;
    tick();
    bus.sWe = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [1:0] r, input logic [31:0] exp);
    bus.sAddr = {28'b0, r, 2'b00};
    #1;
    chk(tag, bus.sRData, exp);
  endtask

  // Expects the DUT in READ of the first word; tog inserts one ungranted cycle per phase
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n, input bit tog);
    logic [31:0] sa, da;
    for (int k = 0; k < n; k++) begin
      sa = s + 32'(4 * k);
      da = d + 32'(4 * k);
      peek("remaining", 2'd3, (32'(n - k) << 16) | 32'h1);
      if (tog) begin
        bus.mGnt = 1'b0;
        tick();
        chk("rd_hold_addr", bus.mAddr, sa);
        chk("rd_hold_req", {31'b0, bus.mReq}, 32'h1);
      end
      bus.mGnt = 1'b1;
      chk("rd_req", {31'b0, bus.mReq}, 32'h1);
      chk("rd_we", {31'b0, bus.mWe}, 32'h0);
      chk("rd_addr", bus.mAddr, sa);
      tick();
      if (tog) begin
        bus.mGnt = 1'b0;
        tick();
        chk("wr_hold_addr", bus.mAddr, da);
        chk("wr_hold_data", bus.mWData, mem(sa));
        bus.mGnt = 1'b1;
      end
      chk("wr_we", {31'b0, bus.mWe}, 32'h1);
      chk("wr_addr", bus.mAddr, da);
      chk("wr_data", bus.mWData, mem(sa));
      tick();
    end
    bus.mGnt = 1'b0;
    chk("end_done", {31'b0, bus.done}, 32'h1);
    chk("end_req", {31'b0, bus.mReq}, 32'h0);
    peek("end_stat", 2'd3, 32'h2);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.sAddr = '0;
    bus.sWData = '0;
    bus.sWe = 1'b0;
    bus.mGnt = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_req", {31'b0, bus.mReq}, 32'h0);
    chk("rst_we", {31'b0, bus.mWe}, 32'h0);
    chk("rst_addr", bus.mAddr, 32'h0);
    chk("rst_wdata", bus.mWData, 32'h0);
    chk("rst_done", {31'b0, bus.done}, 32'h0);
    peek("rst_src", 2'd0, 32'h0);
    peek("rst_len", 2'd2, 32'h0);
    peek("rst_stat", 2'd3, 32'h0);
    // Basic copy with constant grant
    wr(2'd0, 32'h103);
    peek("src_align", 2'd0, 32'h100);
    wr(2'd1, 32'h200);
    wr(2'd2, 32'h4);
    peek("len_rb", 2'd2, 32'h4);
    wr(2'd3, 32'h1);
    run_copy(32'h100, 32'h200, 4, 1'b0);
    // Same copy with alternating grant; START clears done
    wr(2'd3, 32'h1);
    chk("start_clr_done", {31'b0, bus.done}, 32'h0);
    run_copy(32'h100, 32'h200, 4, 1'b1);
    // DONE_CLR, then zero-length START
    wr(2'd3, 32'h2);
    chk("done_clr", {31'b0, bus.done}, 32'h0);
    wr(2'd2, 32'h0);
    wr(2'd3, 32'h1);
    chk("len0_done", {31'b0, bus.done}, 32'h1);
    chk("len0_req", {31'b0, bus.mReq}, 32'h0);
    tick();
    chk("len0_req2", {31'b0, bus.mReq}, 32'h0);
    // START+DONE_CLR together, then writes and START while busy are ignored
    wr(2'd0, 32'h300);
    wr(2'd1, 32'h400);
    wr(2'd2, 32'h3);
    wr(2'd3, 32'h3);
    chk("start_wins", {31'b0, bus.done}, 32'h0);
    wr(2'd0, 32'h900);
    wr(2'd3, 32'h1);
    peek("busy_src", 2'd0, 32'h300);
    chk("busy_addr", bus.mAddr, 32'h300);
    run_copy(32'h300, 32'h400, 3, 1'b0);
    // Address wrap past 0xFFFFFFFC
    wr(2'd0, 32'hFFFF_FFF8);
    wr(2'd1, 32'h500);
    wr(2'd3, 32'h1);
    run_copy(32'hFFFF_FFF8, 32'h500, 3, 1'b0);
    // Reset during the write of the second word of five
    wr(2'd0, 32'h1000);
    wr(2'd1, 32'h2000);
    wr(2'd2, 32'h5);
    wr(2'd3, 32'h1);
    bus.mGnt = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_we", {31'b0, bus.mWe}, 32'h1);
    chk("mid_addr", bus.mAddr, 32'h2004);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mGnt = 1'b0;
    chk("abort_req", {31'b0, bus.mReq}, 32'h0);
    chk("abort_we", {31'b0, bus.mWe}, 32'h0);
    chk("abort_done", {31'b0, bus.done}, 32'h0);
    peek("abort_src", 2'd0, 32'h0);
    peek("abort_dst", 2'd1, 32'h0);
    peek("abort_len", 2'd2, 32'h0);
    peek("abort_stat", 2'd3, 32'h0);
    wr(2'd0, 32'h40);
    wr(2'd1, 32'h80);
    wr(2'd2, 32'h2);
    wr(2'd3, 32'h1);
    run_copy(32'h40, 32'h80, 2, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
